// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared types, constants and address mapping for the data-SRAM to AXI4-Lite bridge.
package data_sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WA   = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } bridgeState_t;

  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // kseg0 and kseg1 are exactly the addresses whose top two bits are 2'b10.
  function automatic logic [31:0] map_addr(input logic [31:0] addr, input logic addrMap);
    logic [31:0] mapped;
    if (addrMap && (addr[31:30] == 2'b10)) begin
      mapped = addr & KSEG_MASK;
    end else begin
      mapped = addr;
    end
    return mapped;
  endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Turns the core's single-cycle data-SRAM port into one-at-a-time AXI4-Lite
// reads and writes, stalling the core while a transaction is outstanding.
module data_sram_axi_bridge
  import data_sram_axi_bridge_pkg::*;
#(
  parameter int ADDR_MAP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_stall,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic MAP_EN = (ADDR_MAP != 0);

  bridgeState_t state_r;
  logic         awDone_r;
  logic         wDone_r;
  logic         abandon_r;

  logic         inFlight_s;
  logic         abandonNext_s;
  logic         awHs_s;
  logic         wHs_s;
  logic         awDoneNext_s;
  logic         wDoneNext_s;
  logic [31:0]  mappedAddr_s;

  // Handshake decode and the abandon bit as it would stand after this cycle.
  always_comb begin
    inFlight_s = 1'b0;
    case (state_r)
      S_AR, S_R, S_WA, S_B: inFlight_s = 1'b1;
      default:              inFlight_s = 1'b0;
    endcase
    abandonNext_s = abandon_r | (inFlight_s & ~data_sram_en);
    awHs_s        = awvalid & awready;
    wHs_s         = wvalid & wready;
    awDoneNext_s  = awDone_r | awHs_s;
    wDoneNext_s   = wDone_r | wHs_s;
    mappedAddr_s  = map_addr(data_sram_addr, MAP_EN);
  end

  assign data_stall = data_sram_en & (state_r != S_DONE);

  // Transaction FSM with registered AXI controls and load-data register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r         <= S_IDLE;
      awDone_r        <= 1'b0;
      wDone_r         <= 1'b0;
      abandon_r       <= 1'b0;
      data_sram_rdata <= 32'h0000_0000;
      araddr          <= 32'h0000_0000;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awaddr          <= 32'h0000_0000;
      awvalid         <= 1'b0;
      wdata           <= 32'h0000_0000;
      wstrb           <= 4'b0000;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          abandon_r <= 1'b0;
          awDone_r  <= 1'b0;
          wDone_r   <= 1'b0;
          if (data_sram_en) begin
            if (data_sram_wen == 4'b0000) begin
              araddr  <= mappedAddr_s;
              arvalid <= 1'b1;
              state_r <= S_AR;
            end else begin
              awaddr  <= mappedAddr_s;
              wdata   <= data_sram_wdata;
              wstrb   <= data_sram_wen;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state_r <= S_WA;
            end
          end
        end
        S_AR: begin
          abandon_r <= abandonNext_s;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            abandon_r <= 1'b0;
            if (abandonNext_s) begin
              state_r <= S_IDLE;
            end else begin
              data_sram_rdata <= rdata;
              state_r         <= S_DONE;
            end
          end else begin
            abandon_r <= abandonNext_s;
          end
        end
        S_WA: begin
          abandon_r <= abandonNext_s;
          if (awHs_s) awvalid <= 1'b0;
          if (wHs_s)  wvalid  <= 1'b0;
          // Address and data channels may complete in either order or together.
          if (awDoneNext_s && wDoneNext_s) begin
            awDone_r <= 1'b0;
            wDone_r  <= 1'b0;
            bready   <= 1'b1;
            state_r  <= S_B;
          end else begin
            awDone_r <= awDoneNext_s;
            wDone_r  <= wDoneNext_s;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            abandon_r <= 1'b0;
            state_r   <= abandonNext_s ? S_IDLE : S_DONE;
          end else begin
            abandon_r <= abandonNext_s;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r   <= S_IDLE;
          abandon_r <= 1'b0;
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          bready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Self-checking bench: the bench plays both the core and a latency-programmable
// AXI4-Lite slave, and predicts stall length, addresses and data from the rules.
module tb_data_sram_axi_bridge;

  localparam int CYCLE_BUDGET = 200;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_stall;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] lastRd = 32'h0000_0000;

  data_sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .data_stall(data_stall),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // kseg0 lives at 0x8000_0000 and kseg1 at 0xA000_0000; both alias physical 0.
  function automatic logic [31:0] refMap(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
    else if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
    else return a;
  endfunction

  task automatic slaveIdle();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0000_0000;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic recover();
    data_sram_en = 1'b0;
    slaveIdle();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    lastRd = 32'h0000_0000;
  endtask

  // Called just after a rising edge with the bridge idle; returns just after the
  // edge that leaves the stall-free cycle, so the next request can follow at once.
  task automatic run_read(input logic [31:0] a, input int arDly, input int rDly);
    logic [31:0] rd;
    logic [31:0] expAddr;
    logic [31:0] gotRd;
    int stallCyc, arCyc, rCyc, firstAr, cyc;
    bit done;
    rd = $urandom; expAddr = refMap(a); gotRd = 32'h0000_0000;
    stallCyc = 0; arCyc = 0; rCyc = 0; firstAr = -1; cyc = 0; done = 1'b0;
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = a; data_sram_wdata = $urandom;
    while (!done && cyc < CYCLE_BUDGET) begin
      @(negedge clk);
      if (!data_stall) begin
        done = 1'b1; gotRd = data_sram_rdata;
        slaveIdle();
      end else begin
        stallCyc++;
        if (arvalid) begin
          if (firstAr < 0) begin
            firstAr = cyc;
            checks++;
            if (araddr !== expAddr) begin
              failures++; $display("FAIL read_araddr: got %h expected %h", araddr, expAddr);
            end
          end
          arready = (arCyc >= arDly); arCyc++;
        end else arready = 1'b0;
        if (rready) begin rvalid = (rCyc >= rDly); rCyc++; end
        else rvalid = 1'b0;
        rdata = rvalid ? rd : $urandom;
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL read_timeout: stall still high after %0d cycles, expected release", cyc);
      recover();
    end else begin
      checks += 4;
      if (stallCyc !== arDly + rDly + 3) begin
        failures++; $display("FAIL read_stall_len: got %0d expected %0d", stallCyc, arDly + rDly + 3);
      end
      if (arCyc !== arDly + 1) begin
        failures++; $display("FAIL read_arvalid_len: got %0d expected %0d", arCyc, arDly + 1);
      end
      if (rCyc !== rDly + 1 || firstAr !== 1) begin
        failures++; $display("FAIL read_phase: rready cycles %0d first ar %0d expected %0d and 1", rCyc, firstAr, rDly + 1);
      end
      if (gotRd !== rd) begin
        failures++; $display("FAIL read_data: got %h expected %h", gotRd, rd);
      end
      lastRd = rd;
    end
  endtask

  task automatic run_write(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                           input int awDly, input int wDly, input int bDly);
    logic [31:0] expAddr;
    logic [31:0] gotRd;
    int stallCyc, awCyc, wCyc, bCyc, firstAw, cyc, expStall;
    bit done;
    expAddr = refMap(a); gotRd = 32'h0000_0000;
    stallCyc = 0; awCyc = 0; wCyc = 0; bCyc = 0; firstAw = -1; cyc = 0; done = 1'b0;
    expStall = ((awDly > wDly) ? awDly : wDly) + bDly + 3;
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = a; data_sram_wdata = wd;
    while (!done && cyc < CYCLE_BUDGET) begin
      @(negedge clk);
      if (!data_stall) begin
        done = 1'b1; gotRd = data_sram_rdata;
        slaveIdle();
      end else begin
        stallCyc++;
        if (awvalid) begin
          if (firstAw < 0) begin
            firstAw = cyc;
            checks++;
            if (awaddr !== expAddr || wdata !== wd || wstrb !== wen) begin
              failures++;
              $display("FAIL write_fields: got addr %h data %h strb %b expected %h %h %b",
                       awaddr, wdata, wstrb, expAddr, wd, wen);
            end
          end
          awready = (awCyc >= awDly); awCyc++;
        end else awready = 1'b0;
        if (wvalid) begin wready = (wCyc >= wDly); wCyc++; end
        else wready = 1'b0;
        if (bready) begin bvalid = (bCyc >= bDly); bCyc++; end
        else bvalid = 1'b0;
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL write_timeout: stall still high after %0d cycles, expected release", cyc);
      recover();
    end else begin
      checks += 4;
      if (stallCyc !== expStall) begin
        failures++; $display("FAIL write_stall_len: got %0d expected %0d", stallCyc, expStall);
      end
      if (awCyc !== awDly + 1 || wCyc !== wDly + 1) begin
        failures++; $display("FAIL write_valid_len: aw %0d w %0d expected %0d %0d", awCyc, wCyc, awDly + 1, wDly + 1);
      end
      if (bCyc !== bDly + 1 || firstAw !== 1) begin
        failures++; $display("FAIL write_phase: bready cycles %0d first aw %0d expected %0d and 1", bCyc, firstAw, bDly + 1);
      end
      if (gotRd !== lastRd) begin
        failures++; $display("FAIL write_rdata_hold: got %h expected %h", gotRd, lastRd);
      end
    end
  endtask

  task automatic test_reset();
    logic [144:0] outs;
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'b0000;
    data_sram_addr = 32'h0000_0000; data_sram_wdata = 32'h0000_0000;
    slaveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {araddr, awaddr, wdata, data_sram_rdata, wstrb, arvalid, rready, awvalid, wvalid, bready, data_stall};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    run_read(32'hBFC0_0010, 0, 0);
  endtask

  task automatic test_write_split();
    run_write(32'h8000_0100, 4'b0011, 32'h1234_5678, 2, 0, 0);
  endtask

  task automatic test_read_delayed();
    run_read(32'h8000_2000, 5, 3);
  endtask

  // Flush during R; a new request arrives while the abandoned read completes.
  task automatic test_flush_read();
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'hA000_0040;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); arready = 1'b1;
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    @(negedge clk); arready = 1'b0;
    checks++;
    if (data_stall !== 1'b0 || rready !== 1'b1) begin
      failures++; $display("FAIL flush_read_r: stall %b rready %b expected 0 1", data_stall, rready);
    end
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_addr = 32'h9000_0080;
    @(negedge clk); rvalid = 1'b1; rdata = 32'h5555_AAAA;
    checks++;
    if (data_stall !== 1'b1) begin
      failures++; $display("FAIL flush_read_stall: got %b expected 1", data_stall);
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    checks++;
    if (rready !== 1'b0 || arvalid !== 1'b0 || data_sram_rdata !== lastRd) begin
      failures++; $display("FAIL flush_read_nodata: rready %b arvalid %b rdata %h expected 0 0 %h",
                           rready, arvalid, data_sram_rdata, lastRd);
    end
    run_read(32'h9000_0080, 0, 0);
  endtask

  // Flush that lands in the very cycle the write response arrives.
  task automatic test_flush_write();
    data_sram_en = 1'b1; data_sram_wen = 4'b1111; data_sram_addr = 32'h0000_1000;
    data_sram_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); awready = 1'b1; wready = 1'b1;
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    @(negedge clk); awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    checks++;
    if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
      failures++; $display("FAIL flush_write_b: bready %b awvalid %b wvalid %b expected 1 0 0", bready, awvalid, wvalid);
    end
    @(posedge clk); #1;
    bvalid = 1'b0;
    run_write(32'hA000_0200, 4'b1000, 32'h0BAD_0001, 1, 3, 2);
  endtask

  task automatic test_back_to_back();
    run_read(32'h0040_0000, 0, 0);
    run_write(32'h8000_0004, 4'b1111, 32'hFEED_BEEF, 0, 0, 0);
    run_read(32'hA000_0004, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [140:0] outs;
    data_sram_en = 1'b1; data_sram_wen = 4'b0101; data_sram_addr = 32'h8000_3000;
    data_sram_wdata = 32'h7777_1111;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      failures++; $display("FAIL reset_mid_pre: awvalid %b wvalid %b expected 1 1", awvalid, wvalid);
    end
    #2 resetn = 1'b0;
    #1;
    outs = {araddr, awaddr, wdata, data_sram_rdata, wstrb, arvalid, rready, awvalid, wvalid, bready};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_mid_async: got %h expected 0", outs);
    end
    data_sram_en = 1'b0;
    @(negedge clk); #2 resetn = 1'b1;
    lastRd = 32'h0000_0000;
    @(posedge clk); #1;
    run_read(32'h1234_5670, 1, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  seg;
    int gap;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      seg = 3'($urandom_range(0, 7));
      a[31:29] = seg;
      a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) begin
        run_read(a, $urandom_range(0, 4), $urandom_range(0, 4));
      end else begin
        run_write(a, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4));
      end
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        data_sram_en = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    data_sram_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_split();
    test_read_delayed();
    test_flush_read();
    test_flush_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
